// File: rtl/eth_axil_regs.sv
// eth_axil_regs: AXI4-Lite responder register bank for the Ethernet control path.
// Ports:
//   s_axi_aclk, s_axi_aresetn  clock and asynchronous active-low reset
//   s_axi_aw*/w*/b*            single-beat write channel (one outstanding)
//   s_axi_ar*/r*               single-beat read channel (one outstanding)
//   ctrl_out                   word 1 RW control
//   sts_in                     word 2 RO status, sampled when a read is captured
//   irq_set                    per-bit set pulses into W1C word 3
//   irq                        registered OR of (word 3 & word 4 mask)
// Map: 0 VERSION (RO), 1 ctrl, 2 status (RO), 3 irq W1C, 4 irq mask, 5.. scratch.
module eth_axil_regs #(
   parameter int          S_AXI_ADDR_WIDTH = 11,
   parameter int          S_AXI_DATA_WIDTH = 32,
   parameter int          NUM_REGS         = 16,
   parameter logic [31:0] VERSION          = 32'h0001_0000
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic [31:0]                   ctrl_out,
   input  logic [31:0]                   sts_in,
   input  logic [31:0]                   irq_set,
   output logic                          irq
);
   typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_e;
   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;
   logic awready_q, awready_d, bvalid_q, bvalid_d;
   logic arready_q, arready_d, rvalid_q, rvalid_d;
   logic irq_q, irq_d;
   logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] regs_d [NUM_REGS];
   logic [S_AXI_ADDR_WIDTH-3:0] w_idx, r_idx;
   logic w_hit, r_hit, w_fire;
   logic unused_addr_lsbs;

   assign w_idx = s_axi_awaddr[S_AXI_ADDR_WIDTH-1:2];
   assign r_idx = s_axi_araddr[S_AXI_ADDR_WIDTH-1:2];
   assign w_hit = 32'(w_idx) < NUM_REGS;
   assign r_hit = 32'(r_idx) < NUM_REGS;
   assign w_fire = w_state_q == W_ACK;
   assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rresp   = rresp_q;
   assign s_axi_rdata   = rdata_q;
   assign ctrl_out      = regs_q[1];
   assign irq           = irq_q;

   always_comb begin
      w_state_d = w_state_q;
      awready_d = 1'b0;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      if (w_state_q == W_IDLE && s_axi_awvalid && s_axi_wvalid) begin
         w_state_d = W_ACK;
         awready_d = 1'b1;
      end
      if (w_state_q == W_ACK) begin
         w_state_d = W_RESP;
         bvalid_d  = 1'b1;
         bresp_d   = w_hit ? 2'b00 : 2'b11;
      end
      if (w_state_q == W_RESP && s_axi_bready) begin
         w_state_d = W_IDLE;
         bvalid_d  = 1'b0;
      end
      // Words 0 and 2 are read-only and word 3 is W1C, so only the rest take wdata directly.
      for (int i = 1; i < NUM_REGS; i++)
         if (w_fire && 32'(w_idx) == i && i != 2 && i != 3) regs_d[i] = s_axi_wdata;
      // Set is OR-ed in after the clear so a same-cycle set wins.
      regs_d[3] = (regs_q[3] & ~((w_fire && 32'(w_idx) == 3) ? s_axi_wdata : 32'h0)) | irq_set;
   end

   always_comb begin
      r_state_d = r_state_q;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      if (r_state_q == R_IDLE && s_axi_arvalid) begin
         r_state_d = R_ACK;
         arready_d = 1'b1;
      end
      if (r_state_q == R_ACK) begin
         r_state_d = R_DATA;
         rvalid_d  = 1'b1;
         rresp_d   = r_hit ? 2'b00 : 2'b11;
         rdata_d   = 32'h0;
         // Reads see the registered bank, so a same-cycle write is not yet visible.
         for (int i = 0; i < NUM_REGS; i++)
            if (32'(r_idx) == i) rdata_d = i == 0 ? VERSION : i == 2 ? sts_in : regs_q[i];
      end
      if (r_state_q == R_DATA && s_axi_rready) begin
         r_state_d = R_IDLE;
         rvalid_d  = 1'b0;
      end
      irq_d = |(regs_q[3] & regs_q[4]);
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= 32'h0;
         irq_q     <= 1'b0;
         regs_q    <= '{default: 32'h0};
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         awready_q <= awready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         irq_q     <= irq_d;
         regs_q    <= regs_d;
      end
   end
endmodule

// File: tb/tb_eth_axil_regs.sv
// tb_eth_axil_regs: directed and randomized bench for eth_axil_regs against a behavioural model.
module tb_eth_axil_regs;
   localparam int NR = 16;
   logic clk = 1'b0, rstn = 1'b0;
   logic [10:0] awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
   logic awready, wready, bvalid, arready, rvalid, irq;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata, ctrl_out;
   logic [31:0] sts_in = '0, rnd_set = '0, dir_set = '0, irq_set;
   logic rnd_on = 1'b0;
   int errors = 0, checks = 0;

   assign irq_set = rnd_on ? rnd_set : dir_set;

   eth_axil_regs #(.S_AXI_ADDR_WIDTH(11), .S_AXI_DATA_WIDTH(32), .NUM_REGS(NR), .VERSION(32'h0001_0000)) dut (
      .s_axi_aclk(clk), .s_axi_aresetn(rstn),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
      .s_axi_wdata(wdata), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
      .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
      .ctrl_out(ctrl_out), .sts_in(sts_in), .irq_set(irq_set), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: register contents plus per-channel "cycles since acceptance" ages.
   logic [31:0] m_regs [NR];
   int w_age = 0, r_age = 0, widx, ridx;
   logic [1:0] m_bresp = '0, m_rresp = '0;
   logic [31:0] m_rdata = '0, clr;
   logic m_irq = 1'b0, irq_next;

   function automatic logic [31:0] word_value(input int i);
      if (i >= NR) return 32'h0;
      if (i == 0) return 32'h0001_0000;
      if (i == 2) return sts_in;
      return m_regs[i];
   endfunction

   always @(posedge clk) begin
      if (!rstn) begin
         w_age = 0; r_age = 0; m_bresp = '0; m_rresp = '0; m_rdata = '0; m_irq = 1'b0;
         foreach (m_regs[i]) m_regs[i] = '0;
      end else begin
         widx = int'(awaddr >> 2);
         ridx = int'(araddr >> 2);
         irq_next = (m_regs[3] & m_regs[4]) != 0;
         if (r_age == 1) begin
            m_rresp = ridx < NR ? 2'b00 : 2'b11;
            m_rdata = word_value(ridx);
         end
         clr = '0;
         if (w_age == 1) begin
            m_bresp = widx < NR ? 2'b00 : 2'b11;
            if (widx == 3) clr = wdata;
            else if (widx == 1 || (widx >= 4 && widx < NR)) m_regs[widx] = wdata;
         end
         m_regs[3] = (m_regs[3] & ~clr) | irq_set;
         m_irq = irq_next;
         w_age = w_age == 0 ? ((awvalid && wvalid) ? 1 : 0) : w_age == 1 ? 2 : (bready ? 0 : 2);
         r_age = r_age == 0 ? (arvalid ? 1 : 0) : r_age == 1 ? 2 : (rready ? 0 : 2);
      end
   end

   always @(posedge clk) begin
      #1;
      chk("awready", 32'(awready), 32'(w_age == 1));
      chk("wready", 32'(wready), 32'(w_age == 1));
      chk("bvalid", 32'(bvalid), 32'(w_age == 2));
      chk("bresp", 32'(bresp), 32'(m_bresp));
      chk("arready", 32'(arready), 32'(r_age == 1));
      chk("rvalid", 32'(rvalid), 32'(r_age == 2));
      chk("rresp", 32'(rresp), 32'(m_rresp));
      chk("rdata", rdata, m_rdata);
      chk("ctrl_out", ctrl_out, m_regs[1]);
      chk("irq", 32'(irq), 32'(m_irq));
   end

   initial forever begin
      @(negedge clk);
      sts_in = $urandom;
      rnd_set = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic do_write(input logic [10:0] a, input logic [31:0] d, input int lead, input int bwait,
                           output logic [1:0] resp, output int lat);
      awaddr = a; wdata = d; awvalid = 1'b1;
      repeat (lead) @(negedge clk);
      wvalid = 1'b1;
      lat = 0;
      while (!bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      if (!bvalid) begin
         checks++; errors++;
         $display("FAIL write_timeout: bvalid=%0b required 1", bvalid);
      end
      resp = bresp;
      repeat (bwait) @(negedge clk);
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic do_read(input logic [10:0] a, input int rwait, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      araddr = a; arvalid = 1'b1;
      while (!rvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      arvalid = 1'b0;
      if (!rvalid) begin
         checks++; errors++;
         $display("FAIL read_timeout: rvalid=%0b required 1", rvalid);
      end
      data = rdata; resp = rresp;
      repeat (rwait) @(negedge clk);
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
   endtask

   function automatic logic [10:0] rnd_addr();
      return ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, NR + 3) * 4 + $urandom_range(0, 3));
   endfunction

   initial begin
      logic [1:0] w_resp, r_resp;
      logic [31:0] data;
      logic [10:0] wa, ra;
      int lat;
      repeat (3) @(negedge clk);
      chk("rst_awready", 32'(awready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ctrl_out", ctrl_out, 0);
      chk("rst_irq", 32'(irq), 0);
      rstn = 1'b1;
      @(negedge clk);
      do_write(11'h004, 32'hA5A5_0001, 0, 0, w_resp, lat);
      chk("ctrl_bresp", 32'(w_resp), 0);
      chk("ctrl_b_latency", 32'(lat), 2);
      chk("ctrl_out_value", ctrl_out, 32'hA5A5_0001);
      do_read(11'h004, 0, data, r_resp);
      chk("ctrl_rdata", data, 32'hA5A5_0001);
      chk("ctrl_rresp", 32'(r_resp), 0);
      do_read(11'h000, 1, data, r_resp);
      chk("version", data, 32'h0001_0000);
      do_write(11'h000, 32'hFFFF_FFFF, 0, 0, w_resp, lat);
      chk("ro_bresp", 32'(w_resp), 0);
      do_read(11'h000, 0, data, r_resp);
      chk("version_kept", data, 32'h0001_0000);
      do_write(11'h010, 32'h1, 0, 0, w_resp, lat);
      dir_set = 32'h5;
      @(negedge clk);
      dir_set = 32'h0;
      chk("irq_not_yet", 32'(irq), 0);
      @(negedge clk);
      chk("irq_asserted", 32'(irq), 1);
      do_read(11'h00C, 0, data, r_resp);
      chk("irq_sts", data, 32'h5);
      do_write(11'h00C, 32'h1, 0, 0, w_resp, lat);
      do_read(11'h00C, 0, data, r_resp);
      chk("irq_sts_cleared", data, 32'h4);
      chk("irq_deasserted", 32'(irq), 0);
      fork
         do_write(11'h00C, 32'h1, 0, 0, w_resp, lat);
         begin
            @(negedge clk);
            dir_set = 32'h1;
            @(negedge clk);
            dir_set = 32'h0;
         end
      join
      do_read(11'h00C, 0, data, r_resp);
      chk("set_wins", data, 32'h5);
      chk("set_wins_irq", 32'(irq), 1);
      do_write(11'h040, 32'hDEAD_BEEF, 0, 0, w_resp, lat);
      chk("decerr_bresp", 32'(w_resp), 3);
      do_write(11'h054, 32'hDEAD_BEEF, 0, 0, w_resp, lat);
      chk("decerr_bresp_hi", 32'(w_resp), 3);
      do_read(11'h040, 0, data, r_resp);
      chk("decerr_rdata", data, 0);
      chk("decerr_rresp", 32'(r_resp), 3);
      do_read(11'h014, 0, data, r_resp);
      chk("scratch_untouched", data, 0);
      fork
         do_write(11'h018, 32'hCAFE_F00D, 3, 5, w_resp, lat);
         repeat (3) begin
            @(negedge clk);
            chk("aw_waits_for_w", 32'(awready), 0);
         end
      join
      chk("lead_bresp", 32'(w_resp), 0);
      chk("lead_latency", 32'(lat), 2);
      do_read(11'h018, 0, data, r_resp);
      chk("lead_rdata", data, 32'hCAFE_F00D);
      fork
         do_write(11'h014, 32'h1234_5678, 0, 0, w_resp, lat);
         do_read(11'h014, 0, data, r_resp);
      join
      chk("concurrent_old", data, 0);
      do_read(11'h014, 0, data, r_resp);
      chk("concurrent_new", data, 32'h1234_5678);
      awaddr = 11'h01C; wdata = 32'h5555_AAAA; awvalid = 1'b1; wvalid = 1'b1;
      lat = 0;
      while (!bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("abort_bvalid_before", 32'(bvalid), 1);
      #2 rstn = 1'b0;
      #1;
      chk("abort_bvalid", 32'(bvalid), 0);
      chk("abort_awready", 32'(awready), 0);
      chk("abort_ctrl_out", ctrl_out, 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("abort_no_resp", 32'(bvalid), 0);
      do_read(11'h014, 0, data, r_resp);
      chk("abort_scratch_reset", data, 0);
      rnd_on = 1'b1;
      for (int k = 0; k < 200; k++) begin
         wa = rnd_addr();
         ra = rnd_addr();
         case ($urandom_range(0, 2))
            0: do_write(wa, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), w_resp, lat);
            1: do_read(ra, $urandom_range(0, 3), data, r_resp);
            default: fork
               do_write(wa, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), w_resp, lat);
               do_read(ra, $urandom_range(0, 3), data, r_resp);
            join
         endcase
      end
      rnd_on = 1'b0;
      repeat (4) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
